mips_avalon_mem_master: RTL

//  Avalon-MM bus master between the MIPS core and the Avalon memory (RAM model in test, system bus in synthesis).

---
 rtl/mips_mem_pkg.sv | 17 +
 rtl/mips_mem_req_latch.sv | 52 +++++
 rtl/mips_avalon_mem_master.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared types and constants for the MIPS Avalon memory master
package mips_mem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      RECOVER
   } state_e;

   typedef enum logic {
      PORT_IFETCH,
      PORT_DATA
   } port_e;

   localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/mips_mem_req_latch.sv
// rtl/mips_mem_req_latch.sv - per-port pending request buffer with strobe capture and grant clear
module mips_mem_req_latch (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req,
   input  logic [31:2] req_addr,
   input  logic        req_we,
   input  logic [3:0]  req_be,
   input  logic [31:0] req_wdata,
   input  logic        busy,
   input  logic        grant,
   output logic        valid,
   output logic [31:2] addr,
   output logic        we,
   output logic [3:0]  be,
   output logic [31:0] wdata
);

   logic        pending_q;
   logic [31:2] addr_q;
   logic        we_q;
   logic [3:0]  be_q;
   logic [31:0] wdata_q;
   logic        accept;

   // A fresh strobe is offered to the arbiter in the same cycle it arrives.
   assign accept = req && !pending_q && !busy;
   assign valid  = pending_q || accept;
   assign addr   = pending_q ? addr_q  : req_addr;
   assign we     = pending_q ? we_q    : req_we;
   assign be     = pending_q ? be_q    : req_be;
   assign wdata  = pending_q ? wdata_q : req_wdata;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pending_q <= 1'b0;
         addr_q    <= '0;
         we_q      <= 1'b0;
         be_q      <= '0;
         wdata_q   <= '0;
      end else if (grant) begin
         pending_q <= 1'b0;
      end else if (accept) begin
         pending_q <= 1'b1;
         addr_q    <= req_addr;
         we_q      <= req_we;
         be_q      <= req_be;
         wdata_q   <= req_wdata;
      end
   end

endmodule

// File: rtl/mips_avalon_mem_master.sv
// rtl/mips_avalon_mem_master.sv - Avalon-MM master arbitrating MIPS fetch and load/store ports
module mips_avalon_mem_master
   import mips_mem_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        ifetch_req,
   input  logic [31:0] ifetch_addr,
   output logic [31:0] ifetch_rdata,
   output logic        ifetch_done,
   input  logic        data_req,
   input  logic        data_we,
   input  logic [31:0] data_addr,
   input  logic [3:0]  data_byteenable,
   input  logic [31:0] data_wdata,
   output logic [31:0] data_rdata,
   output logic        data_done,
   output logic        bus_error,
   output logic [31:0] avm_address,
   output logic [3:0]  avm_byteenable,
   output logic        avm_read,
   output logic        avm_write,
   output logic [31:0] avm_writedata,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   state_e            state_q, state_d;
   port_e             cur_port_q;
   logic [CNT_W-1:0]  wait_cnt_q;

   logic              grant_data, grant_ifetch, finish, abort, timeout_hit;
   logic              i_valid, i_we, d_valid, d_we;
   logic [31:2]       i_addr, d_addr, sel_addr;
   logic [3:0]        i_be, d_be, sel_be;
   logic [31:0]       i_wdata, d_wdata, sel_wdata;
   logic              sel_we;
   logic              unused_addr_lsbs;

   assign unused_addr_lsbs = ^{ifetch_addr[1:0], data_addr[1:0]};

   mips_mem_req_latch u_ifetch_latch (
      .clk       (clk),
      .reset_n   (reset_n),
      .req       (ifetch_req),
      .req_addr  (ifetch_addr[31:2]),
      .req_we    (1'b0),
      .req_be    (BE_WORD),
      .req_wdata (32'h0),
      .busy      ((state_q == ISSUE) && (cur_port_q == PORT_IFETCH)),
      .grant     (grant_ifetch),
      .valid     (i_valid),
      .addr      (i_addr),
      .we        (i_we),
      .be        (i_be),
      .wdata     (i_wdata)
   );

   mips_mem_req_latch u_data_latch (
      .clk       (clk),
      .reset_n   (reset_n),
      .req       (data_req),
      .req_addr  (data_addr[31:2]),
      .req_we    (data_we),
      .req_be    (data_byteenable),
      .req_wdata (data_wdata),
      .busy      ((state_q == ISSUE) && (cur_port_q == PORT_DATA)),
      .grant     (grant_data),
      .valid     (d_valid),
      .addr      (d_addr),
      .we        (d_we),
      .be        (d_be),
      .wdata     (d_wdata)
   );

   assign sel_addr  = grant_data ? d_addr  : i_addr;
   assign sel_we    = grant_data ? d_we    : i_we;
   assign sel_wdata = grant_data ? d_wdata : i_wdata;
   // Reads always move the full word regardless of the requested lanes.
   assign sel_be    = sel_we ? (grant_data ? d_be : i_be) : BE_WORD;

   assign timeout_hit = (TIMEOUT_CYCLES > 0) && avm_waitrequest && (wait_cnt_q == CNT_LAST);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_data   = 1'b0;
      grant_ifetch = 1'b0;
      finish       = 1'b0;
      abort        = 1'b0;
      unique case (state_q)
         IDLE, RECOVER: begin
            if (d_valid) begin
               grant_data = 1'b1;
               state_d    = ISSUE;
            end else if (i_valid) begin
               grant_ifetch = 1'b1;
               state_d      = ISSUE;
            end else begin
               state_d = IDLE;
            end
         end
         ISSUE: begin
            if (!avm_waitrequest) begin
               finish  = 1'b1;
               state_d = RECOVER;
            end else if (timeout_hit) begin
               abort   = 1'b1;
               state_d = RECOVER;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cur_port_q     <= PORT_IFETCH;
         wait_cnt_q     <= '0;
         avm_address    <= '0;
         avm_byteenable <= '0;
         avm_read       <= 1'b0;
         avm_write      <= 1'b0;
         avm_writedata  <= '0;
         ifetch_rdata   <= '0;
         ifetch_done    <= 1'b0;
         data_rdata     <= '0;
         data_done      <= 1'b0;
         bus_error      <= 1'b0;
      end else begin
         ifetch_done <= 1'b0;
         data_done   <= 1'b0;
         bus_error   <= 1'b0;
         if (grant_data || grant_ifetch) begin
            cur_port_q     <= grant_data ? PORT_DATA : PORT_IFETCH;
            wait_cnt_q     <= '0;
            avm_address    <= {sel_addr, 2'b00};
            avm_byteenable <= sel_be;
            avm_read       <= !sel_we;
            avm_write      <= sel_we;
            avm_writedata  <= sel_wdata;
         end else if (finish || abort) begin
            avm_read  <= 1'b0;
            avm_write <= 1'b0;
            bus_error <= abort;
            if (cur_port_q == PORT_DATA) begin
               data_done <= 1'b1;
               if (avm_read) begin
                  data_rdata <= abort ? 32'h0 : avm_readdata;
               end
            end else begin
               ifetch_done  <= 1'b1;
               ifetch_rdata <= abort ? 32'h0 : avm_readdata;
            end
         end else if ((state_q == ISSUE) && avm_waitrequest && (wait_cnt_q != CNT_MAX)) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
         end
      end
   end

endmodule
